// File: rtl/flash_streamer.sv
// Reader side of the four-word flash sample store: snapshots the store on request and
// streams the words out in index order over a valid/ready handshake.
module flash_streamer #(
    parameter int unsigned N = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [N-1:0] i_word0,
    input  logic [N-1:0] i_word1,
    input  logic [N-1:0] i_word2,
    input  logic [N-1:0] i_word3,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [N-1:0] o_data,
    output logic [1:0]   o_index,
    output logic         o_busy,
    output logic         o_done,
    output logic [7:0]   o_frame_cnt
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSend = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0][N-1:0] shadow_q, shadow_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            StIdle: begin
                if (i_start) begin
                    shadow_d = {i_word3, i_word2, i_word1, i_word0};
                    idx_d    = 2'd0;
                    state_d  = StSend;
                end
            end
            StSend: begin
                // o_valid is high throughout SEND, so i_ready alone marks a handshake.
                if (i_ready) begin
                    if (idx_q == 2'd3) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            StDone: begin
                frame_cnt_d = frame_cnt_q + 8'd1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            idx_q       <= 2'd0;
            shadow_q    <= '0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Outputs decode flops only; the store inputs never reach o_data directly.
    assign o_valid     = (state_q == StSend);
    assign o_busy      = (state_q == StSend) || (state_q == StDone);
    assign o_done      = (state_q == StDone);
    assign o_index     = idx_q;
    assign o_data      = shadow_q[idx_q];
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_flash_streamer.sv
// Self-checking bench for flash_streamer: directed scenarios plus random traffic,
// all checked against a queue-based frame model.
module tb_flash_streamer;

    localparam int unsigned N = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         ready = 1'b0;
    logic [N-1:0] w0 = '0, w1 = '0, w2 = '0, w3 = '0;
    logic         o_valid, o_busy, o_done;
    logic [N-1:0] o_data;
    logic [1:0]   o_index;
    logic [7:0]   o_frame_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    flash_streamer #(.N(N)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_word0    (w0),
        .i_word1    (w1),
        .i_word2    (w2),
        .i_word3    (w3),
        .i_ready    (ready),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_index    (o_index),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: remaining words of the current frame, plus a pending done pulse.
    logic [N-1:0] m_q[$];
    bit           m_done = 1'b0;
    logic [7:0]   m_cnt = 8'd0;
    int           hs = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_done = 1'b0;
            m_cnt  = 8'd0;
        end else if (m_q.size() != 0) begin
            if (ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end else if (m_done) begin
            m_done = 1'b0;
            m_cnt  = m_cnt + 8'd1;
        end else if (start) begin
            m_q.push_back(w0);
            m_q.push_back(w1);
            m_q.push_back(w2);
            m_q.push_back(w3);
        end
    end

    // DUT-side handshake count per frame.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) hs = 0;
        else if (o_done) hs = 0;
        else if (o_valid && ready) hs++;
        if (rst_n) cyc++;
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check_eq("valid", 32'(o_valid), 32'(m_q.size() != 0));
            check_eq("busy", 32'(o_busy), 32'((m_q.size() != 0) || m_done));
            check_eq("done", 32'(o_done), 32'(m_done));
            check_eq("frame_cnt", 32'(o_frame_cnt), 32'(m_cnt));
            if (m_q.size() != 0) begin
                check_eq("data", 32'(o_data), 32'(m_q[0]));
                check_eq("index", 32'(o_index), 32'(4 - m_q.size()));
            end
            if (m_done) check_eq("handshakes", 32'(hs), 32'd4);
        end
    end

    task automatic set_words(input logic [N-1:0] a, b, c, d);
        w0 = a; w1 = b; w2 = c; w3 = d;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit ok;
        int held;
        int stall_left;
        int prev;
        logic [7:0] cnt0;

        // Reset values
        #12;
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_data", 32'(o_data), 32'd0);
        check_eq("rst_index", 32'(o_index), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_done", 32'(o_done), 32'd0);
        check_eq("rst_cnt", 32'(o_frame_cnt), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Basic frame, ready held high
        set_words(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("first_word", 32'(o_data), 32'h1111);
        wait_done(ok);
        @(negedge clk);
        check_eq("frame1_cnt", 32'(o_frame_cnt), 32'd1);

        // Stall three cycles on index 2
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        held = 0;
        stall_left = 3;
        for (int k = 0; k < 16; k++) begin
            if (o_valid && o_index == 2'd2) held++;
            if (m_q.size() == 2 && stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
            end else begin
                ready = 1'b1;
            end
            @(negedge clk);
        end
        check_eq("stall_hold", 32'(held), 32'd4);
        ready = 1'b1;

        // Store rewritten right after capture
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        set_words(16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA);
        check_eq("capture_w0", 32'(o_data), 32'h1111);
        repeat (8) @(negedge clk);

        // Start pulses during SEND, last handshake and DONE are ignored
        set_words(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        cnt0 = o_frame_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check_eq("done_cycle", 32'(o_done), 32'd1);
        @(negedge clk);
        start = 1'b0;
        check_eq("no_restart_busy", 32'(o_busy), 32'd0);
        check_eq("one_increment", 32'(o_frame_cnt), 32'(cnt0 + 8'd1));
        @(negedge clk);
        check_eq("no_restart_valid", 32'(o_valid), 32'd0);

        // Reset in the middle of a frame
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_index", 32'(o_index), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(o_valid), 32'd0);
        check_eq("mid_rst_data", 32'(o_data), 32'd0);
        check_eq("mid_rst_index", 32'(o_index), 32'd0);
        check_eq("mid_rst_busy", 32'(o_busy), 32'd0);
        check_eq("mid_rst_cnt", 32'(o_frame_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("no_done_after_rst", 32'(o_done), 32'd0);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("restart_index", 32'(o_index), 32'd0);
        check_eq("restart_data", 32'(o_data), 32'h1111);
        repeat (8) @(negedge clk);

        // 256 back-to-back frames with start held high
        do_reset();
        start = 1'b1;
        prev = 0;
        for (int f = 0; f < 256; f++) begin
            wait_done(ok);
            if (!ok) break;
            if (f > 0) check_eq("period", 32'(cyc - prev), 32'd6);
            prev = cyc;
        end
        start = 1'b0;
        @(negedge clk);
        check_eq("cnt_wrap", 32'(o_frame_cnt), 32'd0);
        repeat (4) @(negedge clk);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            start = ($urandom_range(0, 3) == 0);
            ready = ($urandom_range(0, 2) != 0);
            set_words(N'($urandom), N'($urandom), N'($urandom), N'($urandom));
            @(negedge clk);
        end
        start = 1'b0;
        ready = 1'b1;
        repeat (10) @(negedge clk);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
